// File: rtl/patchk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : patchk_pkg
// Purpose  : Shared types and widths for the pattern_rx_checker slice.
//            BYTE_W   - width of the pattern byte
//            PERIOD_W - width of the update-period measurement
//            state_t  - lock FSM state encoding
// Revision : 1.0 - initial release
// ============================================================================
package patchk_pkg;

  localparam int BYTE_W   = 8;
  localparam int PERIOD_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pattern_rx_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : pattern_rx_checker_if
// Purpose  : Bundles the control inputs and link-status outputs of
//            pattern_rx_checker.
//            ena        - enable (master -> checker)
//            din        - raw asynchronous pattern byte (master -> checker)
//            clear_err  - single-cycle error-count clear (master -> checker)
//            locked     - FSM is in LOCKED (checker -> master)
//            err_pulse  - one-cycle strobe per counted error
//            err_count  - saturating error count
//            last_value - most recently accepted byte
//            period     - clocks between the last two accepted updates
// Revision : 1.0 - initial release
// ============================================================================
interface pattern_rx_checker_if;
  import patchk_pkg::*;

  logic                ena;
  logic [BYTE_W-1:0]   din;
  logic                clear_err;
  logic                locked;
  logic                err_pulse;
  logic [BYTE_W-1:0]   err_count;
  logic [BYTE_W-1:0]   last_value;
  logic [PERIOD_W-1:0] period;

  modport master (
    output ena, din, clear_err,
    input  locked, err_pulse, err_count, last_value, period
  );

  modport slave (
    input  ena, din, clear_err,
    output locked, err_pulse, err_count, last_value, period
  );

endinterface
`default_nettype wire

// File: rtl/patchk_debounce.sv
`default_nettype none
// ============================================================================
// Module   : patchk_debounce
// Purpose  : 2-FF synchroniser, stability counter and update-event generator
//            for the incoming pattern byte.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            i_ena           - enable; low holds the stability count at 0
//            i_din           - asynchronous pattern byte
//            i_last_value    - currently accepted byte (from the FSM)
//            i_empty         - FSM is in EMPTY (accept even a repeat value)
//            o_upd           - one-cycle update event (registered)
//            o_v             - byte carried by the update event (registered)
// Revision : 1.0 - initial release
// ============================================================================
module patchk_debounce import patchk_pkg::*; #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ena,
  input  logic [BYTE_W-1:0] i_din,
  input  logic [BYTE_W-1:0] i_last_value,
  input  logic              i_empty,
  output logic              o_upd,
  output logic [BYTE_W-1:0] o_v
);

  localparam logic [3:0] c_st_max = 4'(STABLE_CYCLES);

  logic [BYTE_W-1:0] r_sync1;
  logic [BYTE_W-1:0] r_sync2;   // synchronised sample s
  logic [3:0]        r_st;
  logic              r_upd;
  logic [BYTE_W-1:0] r_v;

  logic [3:0]        w_st_next;
  logic              w_reach;
  logic              w_fire;

  // The count clears on the same edge that s takes a new value, so it
  // counts consecutive cycles that s has matched its previous sample.
  always_comb begin
    w_st_next = r_st;
    if (r_sync1 != r_sync2) begin
      w_st_next = '0;
    end else if (r_st != c_st_max) begin
      w_st_next = r_st + 4'd1;
    end
  end

  // Fire only on the first arrival at the threshold; saturation keeps a
  // steady byte from re-firing.
  assign w_reach = (w_st_next == c_st_max) && (r_st != c_st_max);
  assign w_fire  = i_ena && w_reach && ((r_sync2 != i_last_value) || i_empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_st    <= '0;
      r_upd   <= 1'b0;
      r_v     <= '0;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
      r_st    <= i_ena ? w_st_next : 4'd0;
      r_upd   <= w_fire;
      if (w_fire) begin
        r_v <= r_sync2;
      end
    end
  end

  assign o_upd = r_upd;
  assign o_v   = r_v;

endmodule
`default_nettype wire

// File: rtl/pattern_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : pattern_rx_checker
// Purpose  : Receive-side checker for the +1 counter pattern. Debounces the
//            input byte, locks onto the +1 sequence, counts sequence errors
//            and reports link status.
// Ports    : clk, reset - clock, synchronous active-high reset
//            bus        - pattern_rx_checker_if.slave (ena, din, clear_err in;
//                         locked, err_pulse, err_count, last_value, period out)
// Params   : STABLE_CYCLES - identical samples needed to accept a byte (1..15)
//            LOCK_COUNT    - good increments needed to lock (1..15)
//            MISS_LIMIT    - consecutive bad updates that drop lock (1..15)
// Macro    : PATCHK_PERIOD_EN - builds the update-period measurement;
//            without it period reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_rx_checker import patchk_pkg::*; #(
  parameter int STABLE_CYCLES = 4,
  parameter int LOCK_COUNT    = 3,
  parameter int MISS_LIMIT    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  pattern_rx_checker_if.slave  bus
);

  localparam logic [3:0] c_lock_cnt = 4'(LOCK_COUNT);
  localparam logic [3:0] c_miss_lim = 4'(MISS_LIMIT);

  state_t              r_state;
  logic [BYTE_W-1:0]   r_last;
  logic [3:0]          r_good_run;
  logic [3:0]          r_miss_run;
  logic                r_locked;
  logic                r_err_pulse;
  logic [BYTE_W-1:0]   r_err_cnt;

  logic                w_empty;
  logic                w_upd_raw;
  logic                w_upd;
  logic [BYTE_W-1:0]   w_v;
  logic                w_good;
  logic                w_err;
  logic [PERIOD_W-1:0] w_period;

  assign w_empty = (r_state == ST_EMPTY);

  patchk_debounce #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .i_ena        (bus.ena),
    .i_din        (bus.din),
    .i_last_value (r_last),
    .i_empty      (w_empty),
    .o_upd        (w_upd_raw),
    .o_v          (w_v)
  );

  // The event is registered inside the debouncer; gating again here keeps the
  // FSM frozen if ena drops in the cycle the event is presented.
  assign w_upd  = w_upd_raw && bus.ena;
  assign w_good = (w_v == (r_last + BYTE_W'(1)));
  assign w_err  = w_upd && (r_state == ST_LOCKED) && !w_good;

  // --------------------------------------------------------------------------
  // Lock FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_last     <= '0;
      r_good_run <= '0;
      r_miss_run <= '0;
      r_locked   <= 1'b0;
    end else if (w_upd) begin
      r_last <= w_v;
      case (r_state)
        ST_EMPTY: begin
          r_good_run <= '0;
          r_state    <= ST_SEARCH;
        end
        ST_SEARCH: begin
          if (w_good) begin
            r_good_run <= r_good_run + 4'd1;
            if ((r_good_run + 4'd1) == c_lock_cnt) begin
              r_state    <= ST_LOCKED;
              r_locked   <= 1'b1;
              r_miss_run <= '0;
            end
          end else begin
            r_good_run <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_good) begin
            r_miss_run <= '0;
          end else begin
            r_miss_run <= r_miss_run + 4'd1;
            if ((r_miss_run + 4'd1) == c_miss_lim) begin
              r_state    <= ST_SEARCH;
              r_locked   <= 1'b0;
              r_good_run <= '0;
            end
          end
        end
        default: begin
          r_state  <= ST_EMPTY;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Error counter: a counted error beats a simultaneous clear, leaving 1.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= w_err;
      if (w_err) begin
        if (bus.clear_err) begin
          r_err_cnt <= BYTE_W'(1);
        end else if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + BYTE_W'(1);
        end
      end else if (bus.clear_err) begin
        r_err_cnt <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Update-period measurement
  // --------------------------------------------------------------------------
`ifdef PATCHK_PERIOD_EN
  logic [PERIOD_W-1:0] r_gap;
  logic [PERIOD_W-1:0] r_period;

  // r_gap restarts at 1 on an event, so on the next event it holds exactly
  // the number of clocks between the two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gap    <= '0;
      r_period <= '0;
    end else begin
      if (w_upd) begin
        r_gap <= PERIOD_W'(1);
      end else if (r_gap != '1) begin
        r_gap <= r_gap + PERIOD_W'(1);
      end
      if (w_upd && (r_state != ST_EMPTY)) begin
        r_period <= r_gap;
      end
    end
  end

  assign w_period = r_period;
`else
  assign w_period = '0;
`endif

  assign bus.locked     = r_locked;
  assign bus.err_pulse  = r_err_pulse;
  assign bus.err_count  = r_err_cnt;
  assign bus.last_value = r_last;
  assign bus.period     = w_period;

endmodule
`default_nettype wire

// File: tb/tb_pattern_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_rx_checker
// Purpose  : Self-checking bench for pattern_rx_checker (defaults:
//            STABLE_CYCLES=4, LOCK_COUNT=3, MISS_LIMIT=2). Honours
//            PATCHK_PERIOD_EN for the expected period values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_rx_checker;
  import patchk_pkg::*;

  typedef struct {
    logic [7:0] din;     // byte driven for this step
    int         ce_at;   // hold cycle on which clear_err pulses (0 = none)
    bit         glitch;  // precede with a 2-cycle 0x55 glitch
    bit         locked;  // expected locked at end of step
    int         err;     // expected err_count
    logic [7:0] last;    // expected last_value
    int         pulses;  // expected err_pulse cycles during the step
  } vec_t;

`ifdef PATCHK_PERIOD_EN
  localparam int c_per_slow = 256;
  localparam int c_per_fast = 12;
`else
  localparam int c_per_slow = 0;
  localparam int c_per_fast = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pattern_rx_checker_if bus ();

  pattern_rx_checker #(
    .STABLE_CYCLES (4),
    .LOCK_COUNT    (3),
    .MISS_LIMIT    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_vec;
  int   n_fail;
  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(input logic [7:0] d, input int ce, input bit g,
                              input bit l, input int e, input logic [7:0] lv,
                              input int p);
    vec_t v;
    v.din = d; v.ce_at = ce; v.glitch = g; v.locked = l;
    v.err = e; v.last = lv; v.pulses = p;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one byte, hold it, then compare the scoreboard entry.
  task automatic run_step(input vec_t v, input int hold);
    vec_t exp;
    int   pulses;
    sb.push_back(v);
    if (v.glitch) begin
      bus.din = 8'h55;
      repeat (2) begin
        @(posedge clk); #1;
      end
    end
    bus.din = v.din;
    pulses  = 0;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk); #1;
      bus.clear_err = (i == v.ce_at);
      if (bus.err_pulse) pulses++;
    end
    bus.clear_err = 1'b0;
    exp = sb.pop_front();
    check($sformatf("locked din=%02h", exp.din), int'(bus.locked), int'(exp.locked));
    check($sformatf("err_count din=%02h", exp.din), int'(bus.err_count), exp.err);
    check($sformatf("last_value din=%02h", exp.din), int'(bus.last_value), int'(exp.last));
    check($sformatf("err_pulses din=%02h", exp.din), pulses, exp.pulses);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] L;
    n_vec = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.ena = 1'b1;
    bus.din = 8'h00;
    bus.clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset locked", int'(bus.locked), 0);
    check("reset err_pulse", int'(bus.err_pulse), 0);
    check("reset err_count", int'(bus.err_count), 0);
    check("reset last_value", int'(bus.last_value), 0);
    check("reset period", int'(bus.period), 0);
    reset = 1'b0;

    // Slow transmitter: one step every 256 clocks, lock on the 4th value.
    run_step(mk(8'h00, 0, 0, 0, 0, 8'h00, 0), 256);
    run_step(mk(8'h01, 0, 0, 0, 0, 8'h01, 0), 256);
    run_step(mk(8'h02, 0, 0, 0, 0, 8'h02, 0), 256);
    check("period slow", int'(bus.period), c_per_slow);
    run_step(mk(8'h03, 0, 0, 1, 0, 8'h03, 0), 256);
    check("period slow locked", int'(bus.period), c_per_slow);

    // Table: locked run, errors, relock, glitch, wrap, clear.
    for (int v = 4; v <= 16; v++) tbl.push_back(mk(8'(v), 0, 0, 1, 0, 8'(v), 0));
    tbl.push_back(mk(8'h13, 0, 0, 1, 1, 8'h13, 1));
    tbl.push_back(mk(8'h1D, 0, 0, 0, 2, 8'h1D, 1));
    tbl.push_back(mk(8'h1E, 0, 0, 0, 2, 8'h1E, 0));
    tbl.push_back(mk(8'h1F, 0, 0, 0, 2, 8'h1F, 0));
    tbl.push_back(mk(8'h20, 0, 0, 1, 2, 8'h20, 0));
    tbl.push_back(mk(8'h20, 0, 1, 1, 2, 8'h20, 0));
    tbl.push_back(mk(8'h21, 0, 0, 1, 2, 8'h21, 0));
    tbl.push_back(mk(8'hFE, 0, 0, 1, 3, 8'hFE, 1));
    tbl.push_back(mk(8'hFF, 0, 0, 1, 3, 8'hFF, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 3, 8'h00, 0));
    tbl.push_back(mk(8'h01, 0, 0, 1, 3, 8'h01, 0));
    tbl.push_back(mk(8'h02, 1, 0, 1, 0, 8'h02, 0));
    for (int i = 0; i < tbl.size(); i++) run_step(tbl[i], 12);
    check("period fast", int'(bus.period), c_per_fast);

    // Drive err_count to saturation with alternating bad/good steps.
    L = 8'h02;
    for (int n = 1; n <= 255; n++) begin
      run_step(mk(L + 8'd2, 0, 0, 1, n, L + 8'd2, 1), 9);
      run_step(mk(L + 8'd3, 0, 0, 1, n, L + 8'd3, 0), 9);
      L = L + 8'd3;
    end
    run_step(mk(L + 8'd2, 0, 0, 1, 255, L + 8'd2, 1), 9);
    // Second consecutive bad step with clear_err on the error edge.
    run_step(mk(L + 8'd4, 6, 0, 0, 1, L + 8'd4, 1), 12);
    L = L + 8'd4;

    // ena low: no acceptance, clear still honoured.
    bus.ena = 1'b0;
    run_step(mk(8'h77, 3, 0, 0, 0, L, 0), 12);
    bus.ena = 1'b1;
    run_step(mk(8'h77, 0, 0, 0, 0, 8'h77, 0), 12);

    // Relock and accumulate 7 errors, then reset mid-operation.
    run_step(mk(8'h78, 0, 0, 0, 0, 8'h78, 0), 9);
    run_step(mk(8'h79, 0, 0, 0, 0, 8'h79, 0), 9);
    run_step(mk(8'h7A, 0, 0, 1, 0, 8'h7A, 0), 9);
    L = 8'h7A;
    for (int n = 1; n <= 7; n++) begin
      run_step(mk(L + 8'd2, 0, 0, 1, n, L + 8'd2, 1), 9);
      run_step(mk(L + 8'd3, 0, 0, 1, n, L + 8'd3, 0), 9);
      L = L + 8'd3;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset locked", int'(bus.locked), 0);
    check("midreset err_count", int'(bus.err_count), 0);
    check("midreset last_value", int'(bus.last_value), 0);
    check("midreset err_pulse", int'(bus.err_pulse), 0);
    check("midreset period", int'(bus.period), 0);
    check("midreset state", int'(dut.r_state), int'(ST_EMPTY));
    reset = 1'b0;
    run_step(mk(8'h42, 0, 0, 0, 0, 8'h42, 0), 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
